// File: rtl/align_add_s_if.sv
// Operand/result handshake bundle for align_add_s.
// master drives operands and out_ready; slave returns the aligned sum.
interface align_add_s_if;
    localparam int unsigned OPD_W = 16;
    localparam int unsigned SUM_W = 11;
    localparam int unsigned EXP_W = 8;

    logic             in_valid;
    logic             in_ready;
    logic             int8;
    logic             op_sub;
    logic [OPD_W-1:0] operand_a;
    logic [OPD_W-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] mantissa_sum;
    logic [EXP_W-1:0] exponent_res;
    logic             signa_int;
    logic             signb_int;
    logic             int8_out;

    modport master (
        output in_valid, int8, op_sub, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, mantissa_sum, exponent_res,
               signa_int, signb_int, int8_out
    );

    modport slave (
        input  in_valid, int8, op_sub, operand_a, operand_b, out_ready,
        output in_ready, out_valid, mantissa_sum, exponent_res,
               signa_int, signb_int, int8_out
    );
endinterface

// File: rtl/align_add_s.sv
// BF16/INT8 exponent compare, mantissa alignment and signed add ahead of normalisation_s.
// BARREL_ALIGN_EN: apply the whole alignment shift at capture instead of 1 bit per cycle.
module align_add_s (
    input  logic         clk,
    input  logic         rst,
    align_add_s_if.slave bus
);
    localparam int unsigned SUM_W = 11;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ALIGN = 2'd1, S_DONE = 2'd2} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_in_ready, r_out_valid, w_in_ready_nxt, w_out_valid_nxt;
    logic [MAN_W-1:0]   r_ma, r_mb;
    logic [CNT_W-1:0]   r_cnt;
    logic [EXP_W-1:0]   r_emax;
    logic               r_shift_b, r_sa, r_sb, r_int8, r_op_sub;
    logic [SUM_W-1:0]   r_mantissa_sum;
    logic [EXP_W-1:0]   r_exponent_res;
    logic               r_signa_int, r_signb_int, r_int8_out;

    logic               w_accept, w_align_end;
    logic [EXP_W-1:0]   w_ea, w_eb, w_diff, w_emax;
    logic               w_a_ge;
    logic [CNT_W-1:0]   w_k, w_cnt_cap;
    logic [MAN_W-1:0]   w_ma_raw, w_mb_raw, w_ma_cap, w_mb_cap, w_neg_b8;
    logic [SUM_W-1:0]   w_ma_ext, w_mb_ext, w_ta, w_tb, w_ia, w_ib, w_sum;
    logic [EXP_W-1:0]   w_exp;
    logic               w_signa, w_signb;

    assign w_accept    = (r_state == S_IDLE) && bus.in_valid;
    assign w_align_end = (r_state == S_ALIGN) && (r_cnt == '0);

    // Capture-side exponent compare; on a tie a is the larger operand.
    assign w_ea     = bus.operand_a[14:7];
    assign w_eb     = bus.operand_b[14:7];
    assign w_a_ge   = (w_ea >= w_eb);
    assign w_diff   = w_a_ge ? (w_ea - w_eb) : (w_eb - w_ea);
    assign w_emax   = w_a_ge ? w_ea : w_eb;
    assign w_k      = bus.int8 ? '0 : ((w_diff > 8'd8) ? 4'd8 : w_diff[3:0]);
    assign w_ma_raw = bus.int8 ? bus.operand_a[7:0] : {(w_ea != '0), bus.operand_a[6:0]};
    assign w_mb_raw = bus.int8 ? bus.operand_b[7:0] : {(w_eb != '0), bus.operand_b[6:0]};

`ifdef BARREL_ALIGN_EN
    assign w_ma_cap  = w_a_ge ? w_ma_raw : (w_ma_raw >> w_k);
    assign w_mb_cap  = w_a_ge ? (w_mb_raw >> w_k) : w_mb_raw;
    assign w_cnt_cap = '0;
`else
    assign w_ma_cap  = w_ma_raw;
    assign w_mb_cap  = w_mb_raw;
    assign w_cnt_cap = w_k;
`endif

    // Result datapath, evaluated from the aligned registers.
    assign w_ma_ext = {3'b000, r_ma};
    assign w_mb_ext = {3'b000, r_mb};
    assign w_ta     = r_sa ? (SUM_W'(0) - w_ma_ext) : w_ma_ext;
    assign w_tb     = r_sb ? (SUM_W'(0) - w_mb_ext) : w_mb_ext;
    assign w_ia     = {{3{r_ma[7]}}, r_ma};
    assign w_ib     = {{3{r_mb[7]}}, r_mb};
    assign w_neg_b8 = (~r_mb) + 8'd1;
    assign w_sum    = r_int8 ? (r_op_sub ? (w_ia - w_ib) : (w_ia + w_ib)) : (w_ta + w_tb);
    assign w_exp    = r_int8 ? '0 : ((r_emax == 8'hFF) ? 8'hFF : (r_emax + 8'd1));
    assign w_signa  = r_int8 ? r_ma[7] : r_sa;
    // -0x80 wraps to 0x80; report it as positive so downstream overflow logic stays right.
    assign w_signb  = r_int8 ? (r_op_sub ? (w_neg_b8[7] && (r_mb != 8'h80)) : r_mb[7]) : r_sb;

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_nxt = S_ALIGN;
            S_ALIGN: if (r_cnt == '0)   w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        if (w_state_nxt == S_IDLE) w_in_ready_nxt  = 1'b1;
        if (w_state_nxt == S_DONE) w_out_valid_nxt = 1'b1;
    end

    // Operand capture, iterative alignment and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ma           <= '0;
            r_mb           <= '0;
            r_cnt          <= '0;
            r_emax         <= '0;
            r_shift_b      <= 1'b0;
            r_sa           <= 1'b0;
            r_sb           <= 1'b0;
            r_int8         <= 1'b0;
            r_op_sub       <= 1'b0;
            r_mantissa_sum <= '0;
            r_exponent_res <= '0;
            r_signa_int    <= 1'b0;
            r_signb_int    <= 1'b0;
            r_int8_out     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ma      <= w_ma_cap;
                r_mb      <= w_mb_cap;
                r_cnt     <= w_cnt_cap;
                r_emax    <= w_emax;
                r_shift_b <= w_a_ge;
                r_sa      <= bus.operand_a[15];
                r_sb      <= bus.operand_b[15] ^ bus.op_sub;
                r_int8    <= bus.int8;
                r_op_sub  <= bus.op_sub;
            end else if ((r_state == S_ALIGN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 4'd1;
                if (r_shift_b) r_mb <= r_mb >> 1;
                else           r_ma <= r_ma >> 1;
            end
            if (w_align_end) begin
                r_mantissa_sum <= w_sum;
                r_exponent_res <= w_exp;
                r_signa_int    <= w_signa;
                r_signb_int    <= w_signb;
                r_int8_out     <= r_int8;
            end
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.mantissa_sum = r_mantissa_sum;
    assign bus.exponent_res = r_exponent_res;
    assign bus.signa_int    = r_signa_int;
    assign bus.signb_int    = r_signb_int;
    assign bus.int8_out     = r_int8_out;
endmodule

// File: tb/tb_align_add_s.sv
// Directed self-checking bench for align_add_s (BF16/INT8 align-and-add stage).
module tb_align_add_s;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    align_add_s_if bus ();

    align_add_s u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int exp_lat(input int k);
`ifdef BARREL_ALIGN_EN
        return 1;
`else
        return k + 1;
`endif
    endfunction

    // Present one operand set, wait for the accept edge, then count edges until out_valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic i8, input logic sub, output int lat);
        bus.operand_a = a;
        bus.operand_b = b;
        bus.int8      = i8;
        bus.op_sub    = sub;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_hs got=%b required=10", {bus.in_ready, bus.out_valid});
        end
        checks++;
        if ({bus.mantissa_sum, bus.exponent_res, bus.signa_int, bus.signb_int, bus.int8_out} !== 22'h0) begin
            errors++; $display("FAIL reset_data got=%h required=0",
                {bus.mantissa_sum, bus.exponent_res, bus.signa_int, bus.signb_int, bus.int8_out});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_bf16_equal();
        int lat;
        run_op(16'h3F80, 16'h3F80, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL eq_lat got=%0d required=1", lat); end
        checks++;
        if ({bus.mantissa_sum, bus.exponent_res, bus.signa_int, bus.signb_int, bus.int8_out}
            !== {11'h100, 8'h80, 3'b000}) begin
            errors++; $display("FAIL eq_result got=%h/%h/%b%b%b required=100/80/000", bus.mantissa_sum,
                bus.exponent_res, bus.signa_int, bus.signb_int, bus.int8_out);
        end
        release_result();
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++; $display("FAIL eq_release got=%b required=10", {bus.in_ready, bus.out_valid});
        end
    endtask

    task automatic test_bf16_sub();
        int lat;
        run_op(16'h3F80, 16'h3F00, 1'b0, 1'b1, lat);
        checks++;
        if (lat !== exp_lat(1)) begin errors++; $display("FAIL sub1_lat got=%0d required=%0d", lat, exp_lat(1)); end
        checks++;
        if ({bus.mantissa_sum, bus.exponent_res, bus.signa_int, bus.signb_int} !== {11'h040, 8'h80, 2'b01}) begin
            errors++; $display("FAIL sub1_result got=%h/%h/%b%b required=040/80/01", bus.mantissa_sum,
                bus.exponent_res, bus.signa_int, bus.signb_int);
        end
        release_result();
        run_op(16'h3F00, 16'h3F80, 1'b0, 1'b1, lat);
        checks++;
        if (lat !== exp_lat(1)) begin errors++; $display("FAIL sub1s_lat got=%0d required=%0d", lat, exp_lat(1)); end
        checks++;
        if ({bus.mantissa_sum, bus.exponent_res} !== {11'h7C0, 8'h80}) begin
            errors++; $display("FAIL sub1s_result got=%h/%h required=7c0/80", bus.mantissa_sum, bus.exponent_res);
        end
        release_result();
    endtask

    task automatic test_large_gap();
        int lat;
        run_op(16'h4780, 16'h3F80, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== exp_lat(8)) begin errors++; $display("FAIL gap_lat got=%0d required=%0d", lat, exp_lat(8)); end
        checks++;
        if ({bus.mantissa_sum, bus.exponent_res} !== {11'h080, 8'h90}) begin
            errors++; $display("FAIL gap_result got=%h/%h required=080/90", bus.mantissa_sum, bus.exponent_res);
        end
        release_result();
    endtask

    task automatic test_bf16_edges();
        int lat;
        run_op(16'h7F80, 16'h7F80, 1'b0, 1'b0, lat);
        checks++;
        if ({bus.mantissa_sum, bus.exponent_res} !== {11'h100, 8'hFF}) begin
            errors++; $display("FAIL expsat got=%h/%h required=100/ff", bus.mantissa_sum, bus.exponent_res);
        end
        release_result();
        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, lat);
        checks++;
        if ({bus.mantissa_sum, bus.exponent_res} !== {11'h000, 8'h01}) begin
            errors++; $display("FAIL zeros got=%h/%h required=000/01", bus.mantissa_sum, bus.exponent_res);
        end
        release_result();
        run_op(16'h0040, 16'h0000, 1'b0, 1'b0, lat);
        checks++;
        if ({bus.mantissa_sum, bus.exponent_res} !== {11'h040, 8'h01}) begin
            errors++; $display("FAIL denorm got=%h/%h required=040/01", bus.mantissa_sum, bus.exponent_res);
        end
        release_result();
    endtask

    task automatic test_int8();
        int lat;
        run_op(16'hAB7F, 16'hCD01, 1'b1, 1'b0, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL i8add_lat got=%0d required=1", lat); end
        checks++;
        if ({bus.mantissa_sum, bus.exponent_res, bus.signa_int, bus.signb_int, bus.int8_out}
            !== {11'h080, 8'h00, 3'b001}) begin
            errors++; $display("FAIL i8add got=%h/%h/%b%b%b required=080/00/001", bus.mantissa_sum,
                bus.exponent_res, bus.signa_int, bus.signb_int, bus.int8_out);
        end
        release_result();
        run_op(16'h0000, 16'h0080, 1'b1, 1'b1, lat);
        checks++;
        if ({bus.mantissa_sum, bus.signa_int, bus.signb_int} !== {11'h080, 2'b00}) begin
            errors++; $display("FAIL i8sub80 got=%h/%b%b required=080/00", bus.mantissa_sum,
                bus.signa_int, bus.signb_int);
        end
        release_result();
        run_op(16'h0005, 16'h0003, 1'b1, 1'b1, lat);
        checks++;
        if ({bus.mantissa_sum, bus.signa_int, bus.signb_int} !== {11'h002, 2'b01}) begin
            errors++; $display("FAIL i8sub got=%h/%b%b required=002/01", bus.mantissa_sum,
                bus.signa_int, bus.signb_int);
        end
        release_result();
        run_op(16'h0080, 16'h00FF, 1'b1, 1'b0, lat);
        checks++;
        if ({bus.mantissa_sum, bus.signa_int, bus.signb_int} !== {11'h77F, 2'b11}) begin
            errors++; $display("FAIL i8neg got=%h/%b%b required=77f/11", bus.mantissa_sum,
                bus.signa_int, bus.signb_int);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(16'h3F80, 16'h3F80, 1'b0, 1'b0, lat);
        bus.operand_a = 16'h0005;
        bus.operand_b = 16'h0003;
        bus.int8      = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.mantissa_sum, bus.exponent_res} !== {2'b01, 11'h100, 8'h80}) begin
                errors++; $display("FAIL bp_hold[%0d] got=%b%b/%h/%h required=01/100/80", i, bus.in_ready,
                    bus.out_valid, bus.mantissa_sum, bus.exponent_res);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++; $display("FAIL bp_release got=%b required=10", {bus.in_ready, bus.out_valid});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++; $display("FAIL bp_noaccept got=%b required=10", {bus.in_ready, bus.out_valid});
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(16'h3F80, 16'h3F00, 1'b0, 1'b0, lat);
        release_result();
        run_op(16'h0010, 16'h0020, 1'b1, 1'b0, lat);
        checks++;
        if ({bus.mantissa_sum, bus.int8_out} !== {11'h030, 1'b1} || lat !== 1) begin
            errors++; $display("FAIL b2b got=%h/%b lat=%0d required=030/1 lat=1", bus.mantissa_sum,
                bus.int8_out, lat);
        end
        release_result();
    endtask

    task automatic test_reset_mid_align();
        int lat;
        bus.operand_a = 16'h4780;
        bus.operand_b = 16'h3F80;
        bus.int8      = 1'b0;
        bus.op_sub    = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.mantissa_sum, bus.exponent_res} !== {2'b10, 19'h0}) begin
            errors++; $display("FAIL rst_async got=%b%b/%h/%h required=10/000/00", bus.in_ready,
                bus.out_valid, bus.mantissa_sum, bus.exponent_res);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++; $display("FAIL rst_hold got=%b required=10", {bus.in_ready, bus.out_valid});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(16'h3F80, 16'h3F80, 1'b0, 1'b0, lat);
        checks++;
        if ({bus.mantissa_sum, bus.exponent_res} !== {11'h100, 8'h80} || lat !== 1) begin
            errors++; $display("FAIL rst_recover got=%h/%h lat=%0d required=100/80 lat=1",
                bus.mantissa_sum, bus.exponent_res, lat);
        end
        release_result();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.int8      = 1'b0;
        bus.op_sub    = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_bf16_equal();
        test_bf16_sub();
        test_large_gap();
        test_bf16_edges();
        test_int8();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_align();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
